// File: rtl/snake_step_ctrl.sv
// Snake head stepping controller.
// Each accepted game tick moves the head one cell in the latched direction.
// The playfield wraps at its edges like a torus. The new head is offered to
// the body/collision logic over a valid/ready handshake. A requested
// 180-degree reversal is filtered out. A tick that arrives while a step is
// still unacknowledged is dropped and reported with a one-cycle overrun pulse.
module snake_step_ctrl #(
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int XW      = 6,
  parameter int YW      = 5,
  parameter int START_X = 20,
  parameter int START_Y = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          enable,
  input  logic [1:0]    dir_req,
  input  logic          dir_req_valid,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    dir_cur,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [15:0]   step_count,
  output logic          overrun
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } state_t;

  state_t        state;
  logic [1:0]    dir_next;
  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;
  logic          dir_accept;

  // Wrapping increment/decrement helpers keep the head inside the playfield.
  function automatic logic [XW-1:0] x_inc(input logic [XW-1:0] x);
    return (x == X_MAX) ? '0 : x + XW'(1);
  endfunction

  function automatic logic [XW-1:0] x_dec(input logic [XW-1:0] x);
    return (x == '0) ? X_MAX : x - XW'(1);
  endfunction

  function automatic logic [YW-1:0] y_inc(input logic [YW-1:0] y);
    return (y == Y_MAX) ? '0 : y + YW'(1);
  endfunction

  function automatic logic [YW-1:0] y_dec(input logic [YW-1:0] y);
    return (y == '0) ? Y_MAX : y - YW'(1);
  endfunction

  // Candidate next head: the current head moved one cell along dir_next.
  always_comb begin
    step_x = head_x;
    step_y = head_y;
    case (dir_next)
      DIR_UP:    step_y = y_dec(head_y);
      DIR_RIGHT: step_x = x_inc(head_x);
      DIR_DOWN:  step_y = y_inc(head_y);
      DIR_LEFT:  step_x = x_dec(head_x);
      default:   ;
    endcase
  end

  // A request is accepted unless it points straight back along the last step.
  assign dir_accept = dir_req_valid && (dir_req != (dir_cur ^ 2'b10));

  // Control FSM with registered head, direction, handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      head_x     <= X_START;
      head_y     <= Y_START;
      dir_cur    <= DIR_RIGHT;
      dir_next   <= DIR_RIGHT;
      step_valid <= 1'b0;
      step_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (dir_accept) begin
        dir_next <= dir_req;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick) begin
            head_x     <= step_x;
            head_y     <= step_y;
            dir_cur    <= dir_next;
            step_valid <= 1'b1;
            state      <= PEND;
          end
        end
        PEND: begin
          if (step_ready) begin
            step_count <= step_count + 16'd1;
            if (tick) begin
              // Back-to-back step: the tick is accepted on the handshake edge.
              head_x  <= step_x;
              head_y  <= step_y;
              dir_cur <= dir_next;
            end else begin
              step_valid <= 1'b0;
              state      <= enable ? RUN : IDLE;
            end
          end else if (tick) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          step_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Testbench for snake_step_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the stepping rules.
module tb_snake_step_ctrl;

  localparam int GRID_W = 40;
  localparam int GRID_H = 30;
  localparam int XW     = 6;
  localparam int YW     = 5;

  logic          clk;
  logic          rst;
  logic          tick;
  logic          enable;
  logic [1:0]    dir_req;
  logic          dir_req_valid;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [1:0]    dir_cur;
  logic          step_valid;
  logic          step_ready;
  logic [15:0]   step_count;
  logic          overrun;

  int checks;
  int failures;

  // Behavioural model state.
  int m_x, m_y, m_dcur, m_dnext, m_sv, m_cnt, m_ovr;
  bit m_running;   // game started (enable seen) and not waiting on a step
  int saved_cnt, saved_x, saved_y;

  snake_step_ctrl #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW),
    .START_X(20), .START_Y(15)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .head_x(head_x), .head_y(head_y), .dir_cur(dir_cur),
    .step_valid(step_valid), .step_ready(step_ready),
    .step_count(step_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("head_x", int'(head_x), m_x);
    chk("head_y", int'(head_y), m_y);
    chk("dir_cur", int'(dir_cur), m_dcur);
    chk("step_valid", int'(step_valid), m_sv);
    chk("step_count", int'(step_count), m_cnt);
    chk("overrun", int'(overrun), m_ovr);
  endtask

  task automatic model_reset();
    m_x = 20; m_y = 15; m_dcur = 1; m_dnext = 1;
    m_sv = 0; m_cnt = 0; m_ovr = 0; m_running = 0;
  endtask

  // Move the model head one cell along m_dnext on the torus.
  task automatic model_advance();
    case (m_dnext)
      0: m_y = (m_y + GRID_H - 1) % GRID_H;
      1: m_x = (m_x + 1) % GRID_W;
      2: m_y = (m_y + 1) % GRID_H;
      default: m_x = (m_x + GRID_W - 1) % GRID_W;
    endcase
    m_dcur = m_dnext;
    m_sv   = 1;
  endtask

  // One clock edge of the rules, given the inputs seen before that edge.
  task automatic model_edge(input bit t, input bit e, input int d, input bit dv, input bit r);
    int new_dnext;
    new_dnext = (dv && d != (m_dcur ^ 2)) ? d : m_dnext;
    m_ovr = 0;
    if (m_sv == 1) begin
      if (r) begin
        m_cnt = (m_cnt + 1) % 65536;
        if (t) model_advance();
        else begin
          m_sv = 0;
          m_running = e;
        end
      end else if (t) begin
        m_ovr = 1;
      end
    end else if (!m_running) begin
      if (e) m_running = 1;
    end else begin
      if (!e) m_running = 0;
      else if (t) model_advance();
    end
    m_dnext = new_dnext;
  endtask

  // Drive one cycle of inputs (at a falling edge), then compare after the next edge.
  task automatic cyc(input bit t, input bit e, input logic [1:0] d, input bit dv, input bit r);
    tick = t; enable = e; dir_req = d; dir_req_valid = dv; step_ready = r;
    model_edge(t, e, int'(d), dv, r);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; tick = 0; enable = 0; dir_req = 0; dir_req_valid = 0; step_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    chk("reset_head_x_lit", int'(head_x), 20);
    chk("reset_head_y_lit", int'(head_y), 15);
    chk("reset_dir_lit", int'(dir_cur), 1);
    rst = 1'b0;

    // 1: first step with ready tied high.
    cyc(0, 1, 2'd0, 0, 1);
    cyc(1, 1, 2'd0, 0, 1);
    chk("t1_head_x_lit", int'(head_x), 21);
    chk("t1_sv_lit", int'(step_valid), 1);
    cyc(0, 1, 2'd0, 0, 1);
    chk("t1_count_lit", int'(step_count), 1);
    chk("t1_sv_drop_lit", int'(step_valid), 0);

    // 2: wrap on the right edge, then wrap on the top edge.
    for (int i = 0; i < 18; i++) cyc(1, 1, 2'd0, 0, 1);
    chk("t2_x39_lit", int'(head_x), 39);
    cyc(1, 1, 2'd0, 0, 1);
    chk("t2_xwrap_lit", int'(head_x), 0);
    cyc(0, 1, 2'd0, 1, 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 2'd0, 0, 1);
    chk("t2_ywrap_lit", int'(head_y), 29);
    chk("t2_x_lit", int'(head_x), 0);

    // 3: reversal filtering and last-accepted-request-wins.
    cyc(0, 1, 2'd1, 1, 1);
    cyc(1, 1, 2'd0, 0, 1);
    chk("t3_right_lit", int'(head_x), 1);
    cyc(0, 1, 2'd3, 1, 1);
    cyc(1, 1, 2'd0, 0, 1);
    chk("t3_rev_ignored_lit", int'(head_x), 2);
    cyc(0, 1, 2'd0, 1, 1);
    cyc(0, 1, 2'd3, 1, 1);
    cyc(1, 1, 2'd0, 0, 1);
    chk("t3_up_lit", int'(head_y), 28);
    chk("t3_dir_up_lit", int'(dir_cur), 0);

    // 4: ticks while the step is unacknowledged are dropped.
    saved_cnt = m_cnt;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 2'd0, 0, 0);
      chk("t4_overrun_lit", int'(overrun), 1);
      chk("t4_head_hold_lit", int'(head_y), 28);
    end
    cyc(0, 1, 2'd0, 0, 0);
    chk("t4_overrun_clear_lit", int'(overrun), 0);
    cyc(0, 1, 2'd0, 0, 1);
    chk("t4_count_inc_lit", int'(step_count), saved_cnt + 1);

    // 5: handshake and tick in the same cycle.
    cyc(1, 1, 2'd0, 0, 1);
    chk("t5_y_lit", int'(head_y), 27);
    cyc(1, 1, 2'd0, 0, 1);
    chk("t5_sv_held_lit", int'(step_valid), 1);
    chk("t5_y2_lit", int'(head_y), 26);
    chk("t5_no_overrun_lit", int'(overrun), 0);

    // 6: enable low in PEND, motionless IDLE, then reset mid-PEND.
    cyc(0, 0, 2'd0, 0, 0);
    cyc(0, 0, 2'd0, 0, 0);
    chk("t6_sv_held_lit", int'(step_valid), 1);
    cyc(0, 0, 2'd0, 0, 1);
    chk("t6_sv_drop_lit", int'(step_valid), 0);
    saved_x = m_x; saved_y = m_y;
    for (int i = 0; i < 3; i++) cyc(1, 0, 2'd0, 0, 1);
    chk("t6_idle_x_lit", int'(head_x), 26 - 26 + saved_x);
    chk("t6_idle_y_lit", int'(head_y), 26);
    cyc(0, 1, 2'd0, 0, 0);
    cyc(1, 1, 2'd0, 0, 0);
    chk("t6_pend_sv_lit", int'(step_valid), 1);
    do_reset();
    chk("t6_rst_sv_lit", int'(step_valid), 0);
    chk("t6_rst_x_lit", int'(head_x), 20);
    chk("t6_rst_cnt_lit", int'(step_count), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
